// File: rtl/count_sampler.sv
// Decimating sampler for a free-running counter. Every DIV enabled cycles the
// value is queued, along with a flag saying whether it went backwards since the last sample.
module count_sampler #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int DIV   = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         value,
  input  logic                     sample_en,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_wrap,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);

  logic [DW-1:0]    div_cnt_reg, div_cnt_next;
  logic [WIDTH-1:0] prev_value_reg;
  logic             wrap_pending_reg, wrap_pending_next;
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]    count_reg, count_next;
  logic [7:0]       drop_cnt_reg, drop_cnt_next;

  logic [WIDTH-1:0] data_mem [DEPTH];
  logic             wrap_mem [DEPTH];
  logic [DEPTH-1:0] entry_we;

  logic tick, wrap_now, pop, push_ok, drop, entry_wrap;

  always_comb begin
    tick       = sample_en && (div_cnt_reg == DIV_LAST);
    wrap_now   = (value < prev_value_reg);
    entry_wrap = wrap_pending_reg | wrap_now;
    pop        = out_valid && out_ready;
    // A full FIFO still takes the sample when the head leaves in the same cycle.
    push_ok    = tick && (!full || pop);
    drop       = tick && full && !pop;
  end

  always_comb begin
    div_cnt_next = div_cnt_reg;
    if (sample_en) begin
      div_cnt_next = tick ? '0 : div_cnt_reg + 1'b1;
    end
    wrap_pending_next = tick ? 1'b0 : entry_wrap;
  end

  always_comb begin
    count_next = count_reg;
    case ({push_ok, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != 8'hFF)) begin
      drop_cnt_next = drop_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_reg      <= '0;
      prev_value_reg   <= '0;
      wrap_pending_reg <= 1'b0;
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      drop_cnt_reg     <= '0;
    end else begin
      div_cnt_reg      <= div_cnt_next;
      prev_value_reg   <= value;
      wrap_pending_reg <= wrap_pending_next;
      count_reg        <= count_next;
      drop_cnt_reg     <= drop_cnt_next;
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_we
      assign entry_we[gi] = push_ok && (wr_ptr_reg == AW'(gi));
    end
  endgenerate

  // Storage is cleared on reset so the head reads zero until the first push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        data_mem[i] <= '0;
        wrap_mem[i] <= 1'b0;
      end else if (entry_we[i]) begin
        data_mem[i] <= value;
        wrap_mem[i] <= entry_wrap;
      end
    end
  end

  assign out_data  = data_mem[rd_ptr_reg];
  assign out_wrap  = wrap_mem[rd_ptr_reg];
  assign out_valid = (count_reg != '0);
  assign count     = count_reg;
  assign full      = (count_reg == COUNT_FULL);
  assign drop_cnt  = drop_cnt_reg;

endmodule

// File: tb/tb_count_sampler.sv
// Bench for count_sampler: queue-based reference model compared every cycle,
// directed scenarios with hand-computed values, then randomized traffic.
module tb_count_sampler;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int DIV   = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] value = '0;
  logic             sample_en = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic             out_wrap;
  logic             out_valid;
  logic [2:0]       count;
  logic             full;
  logic [7:0]       drop_cnt;

  count_sampler #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DIV(DIV)) dut (
    .clk       (clk),
    .reset     (reset),
    .value     (value),
    .sample_en (sample_en),
    .out_data  (out_data),
    .out_wrap  (out_wrap),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .count     (count),
    .full      (full),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: enabled-cycle count since reset, sample queue, saturating drops.
  logic [8:0] mq [$];
  int         m_en_cycles = 0;
  int         m_prev = 0;
  bit         m_pend = 0;
  int         m_drops = 0;
  bit         m_pushed = 0;
  bit         cmp_on = 0;

  always @(posedge clk) begin
    if (reset) begin
      mq.delete();
      m_en_cycles = 0;
      m_prev = 0;
      m_pend = 0;
      m_drops = 0;
      m_pushed = 0;
    end else begin
      bit wn, tk, pp, acc;
      wn  = (int'(value) < m_prev);
      tk  = sample_en && (((m_en_cycles + 1) % DIV) == 0);
      pp  = (mq.size() != 0) && out_ready;
      acc = tk && ((mq.size() < DEPTH) || pp);
      if (tk && !acc && m_drops < 255) m_drops++;
      if (pp) void'(mq.pop_front());
      if (acc) begin
        mq.push_back({m_pend | wn, value});
        m_pushed = 1;
      end
      m_pend = tk ? 1'b0 : (m_pend | wn);
      m_prev = int'(value);
      if (sample_en) m_en_cycles++;
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      chk("out_valid", int'(out_valid), int'(mq.size() != 0));
      chk("count", int'(count), mq.size());
      chk("full", int'(full), int'(mq.size() == DEPTH));
      chk("drop_cnt", int'(drop_cnt), m_drops);
      if (mq.size() != 0) begin
        chk("out_data", int'(out_data), int'(mq[0][7:0]));
        chk("out_wrap", int'(out_wrap), int'(mq[0][8]));
      end else if (!m_pushed) begin
        chk("out_data_idle", int'(out_data), 0);
        chk("out_wrap_idle", int'(out_wrap), 0);
      end
    end
  end

  // Called at a falling edge: applies inputs for the next rising edge, returns at the following falling edge.
  task automatic step(input logic [7:0] v, input logic en, input logic rdy, input logic rst);
    value = v;
    sample_en = en;
    out_ready = rdy;
    reset = rst;
    @(negedge clk);
  endtask

  int exp_pop [5] = '{3, 7, 11, 15, 27};
  logic [7:0] ramp [8] = '{8'hFC, 8'hFD, 8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
  logic [7:0] cv;

  initial begin
    @(negedge clk);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd0, 1'b0, 1'b0, 1'b1);
    cmp_on = 1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_count", int'(count), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    chk("rst_data", int'(out_data), 0);

    // Basic decimation into a stalled sink.
    for (int i = 0; i < 16; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
    chk("dec_count", int'(count), 4);
    chk("dec_full", int'(full), 1);
    chk("dec_head", int'(out_data), 3);
    for (int i = 16; i < 24; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
    chk("ovf_drop", int'(drop_cnt), 2);
    chk("ovf_head", int'(out_data), 3);
    for (int k = 0; k < 5; k++) begin
      chk("drain_order", int'(out_data), exp_pop[k]);
      step(8'(24 + k), 1'b1, 1'b1, 1'b0);
    end
    chk("drain_drop", int'(drop_cnt), 2);
    for (int i = 0; i < 6; i++) step(8'd0, 1'b0, 1'b1, 1'b0);

    // Natural wrap 0xFF -> 0x00.
    step(8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(ramp[i], 1'b1, 1'b0, 1'b0);
    chk("wrap_count", int'(count), 2);
    chk("wrap_head0", int'(out_data), 8'hFF);
    chk("wrap_flag0", int'(out_wrap), 0);
    step(8'h03, 1'b0, 1'b1, 1'b0);
    chk("wrap_head1", int'(out_data), 8'h03);
    chk("wrap_flag1", int'(out_wrap), 1);

    // Upstream counter reset mid-period: 4,5,0,1.
    step(8'd0, 1'b0, 1'b0, 1'b1);
    step(8'd4, 1'b1, 1'b0, 1'b0);
    step(8'd5, 1'b1, 1'b0, 1'b0);
    step(8'd0, 1'b1, 1'b0, 1'b0);
    step(8'd1, 1'b1, 1'b0, 1'b0);
    chk("uprst_data", int'(out_data), 1);
    chk("uprst_flag", int'(out_wrap), 1);

    // Mid-operation reset with count=3, drop_cnt=5.
    step(8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 36; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
    step(8'd36, 1'b0, 1'b1, 1'b0);
    chk("mid_count", int'(count), 3);
    chk("mid_drop", int'(drop_cnt), 5);
    step(8'd40, 1'b1, 1'b0, 1'b1);
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_drop", int'(drop_cnt), 0);
    for (int i = 0; i < 3; i++) step(8'(50 + i), 1'b1, 1'b0, 1'b0);
    chk("restart_early", int'(count), 0);
    step(8'd53, 1'b1, 1'b0, 1'b0);
    chk("restart_tick", int'(count), 1);
    chk("restart_data", int'(out_data), 53);

    // Pause: no pushes while disabled.
    for (int i = 0; i < 10; i++) step(8'(60 + i), 1'b0, 1'b0, 1'b0);
    chk("pause_count", int'(count), 1);

    // Saturation of the drop counter.
    step(8'd0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 1220; i++) step(8'(i), 1'b1, 1'b0, 1'b0);
    chk("sat_drop", int'(drop_cnt), 255);

    // Randomized traffic: mostly counting, with jumps, pauses, random sink and rare resets.
    cv = 8'd0;
    for (int i = 0; i < 3000; i++) begin
      logic en, rdy, rst;
      en  = ($urandom_range(0, 3) != 0);
      rdy = ((i / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 19) == 0) cv = 8'($urandom_range(0, 255));
      else cv = cv + 8'd1;
      step(cv, en, rdy, rst);
    end

    cmp_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
